seg_frame_scheduler: RTL and testbench

//  Sequences 4-digit frames into the 7-seg encoder / 74HC595 chain, one digit per refresh tick.

---
 rtl/seg_frame_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_seg_frame_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_frame_scheduler.sv
// ============================================================================
// Module  : seg_frame_scheduler
// Purpose : Arbitrates 4-digit frames between a time source and an override
//           source and issues them one digit per refresh tick to the encoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_frame_scheduler #(
    parameter logic [3:0] BLANK_CODE = 4'd10,
    parameter int         NUM_DIGITS = 4,
    localparam int        DIGIT_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int        FRAME_W    = 4 * NUM_DIGITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_i,
    input  logic               a_valid_i,
    input  logic [FRAME_W-1:0] a_frame_i,
    input  logic               a_colon_i,
    input  logic               b_valid_i,
    input  logic [FRAME_W-1:0] b_frame_i,
    input  logic               b_colon_i,
    output logic               b_ack_o,
    input  logic [1:0]         bright_i,
    input  logic               sh_ready_i,
    output logic               sh_start_o,
    output logic [3:0]         disp_o,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               colon_o,
    output logic               frame_src_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_GAP   = 3'd3,
        S_WAIT  = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    localparam logic [FRAME_W-1:0] BLANK_FRAME = {NUM_DIGITS{BLANK_CODE}};
    localparam logic [DIGIT_W-1:0] LAST_DIGIT  = DIGIT_W'(NUM_DIGITS - 1);

    state_t               state_q,     state_d;
    logic                 tick_pend_q, tick_pend_d;
    logic [1:0]           frame_cnt_q, frame_cnt_d;
    logic [DIGIT_W-1:0]   digit_q,     digit_d;
    logic [FRAME_W-1:0]   frame_q,     frame_d;
    logic                 colon_q,     colon_d;
    logic                 src_q,       src_d;
    logic [3:0]           disp_q,      disp_d;
    logic [DIGIT_W-1:0]   digit_out_q, digit_out_d;
    logic                 colon_out_q, colon_out_d;
    logic                 tick_seen;
    logic                 b_ack;

    // Digit 0 lives in the most significant nibble of the frame.
    function automatic logic [3:0] digit_of(input logic [FRAME_W-1:0] f,
                                            input logic [DIGIT_W-1:0] idx);
        logic [3:0] r;
        r = BLANK_CODE;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (DIGIT_W'(i) == idx) begin
                r = f[(NUM_DIGITS-1-i)*4 +: 4];
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tick_pend_q <= 1'b0;
            frame_cnt_q <= 2'd0;
            digit_q     <= '0;
            frame_q     <= '0;
            colon_q     <= 1'b0;
            src_q       <= 1'b0;
            disp_q      <= 4'd0;
            digit_out_q <= '0;
            colon_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_pend_q <= tick_pend_d;
            frame_cnt_q <= frame_cnt_d;
            digit_q     <= digit_d;
            frame_q     <= frame_d;
            colon_q     <= colon_d;
            src_q       <= src_d;
            disp_q      <= disp_d;
            digit_out_q <= digit_out_d;
            colon_out_q <= colon_out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_seen   = tick_pend_q | tick_i;
        tick_pend_d = tick_seen;
        frame_cnt_d = frame_cnt_q;
        digit_d     = digit_q;
        frame_d     = frame_q;
        colon_d     = colon_q;
        src_d       = src_q;
        disp_d      = disp_q;
        digit_out_d = digit_out_q;
        colon_out_d = colon_out_q;
        b_ack       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tick_seen) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                if (b_valid_i) begin
                    src_d   = 1'b1;
                    frame_d = b_frame_i;
                    colon_d = b_colon_i;
                end else if (a_valid_i) begin
                    src_d   = 1'b0;
                    frame_d = a_frame_i;
                    colon_d = a_colon_i;
                end else begin
                    src_d   = 1'b0;
                    frame_d = BLANK_FRAME;
                    colon_d = 1'b0;
                end
                // Brightness blanking hides content but keeps the source identity.
                if (frame_cnt_q > bright_i) begin
                    frame_d = BLANK_FRAME;
                    colon_d = 1'b0;
                end
                digit_d     = '0;
                disp_d      = digit_of(frame_d, '0);
                digit_out_d = '0;
                colon_out_d = colon_d;
                state_d     = S_ISSUE;
            end

            S_ISSUE: begin
                if (sh_ready_i) begin
                    tick_pend_d = 1'b0;
                    state_d     = S_GAP;
                end
            end

            S_GAP: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (sh_ready_i) begin
                    if (digit_q == LAST_DIGIT) begin
                        b_ack       = src_q;
                        frame_cnt_d = frame_cnt_q + 2'd1;
                        state_d     = S_IDLE;
                    end else begin
                        digit_d = digit_q + DIGIT_W'(1);
                        state_d = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (tick_seen) begin
                    disp_d      = digit_of(frame_q, digit_q);
                    digit_out_d = digit_q;
                    colon_out_d = colon_q;
                    state_d     = S_ISSUE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sh_start_o  = (state_q == S_ISSUE);
    assign b_ack_o     = b_ack;
    assign disp_o      = disp_q;
    assign digit_o     = digit_out_q;
    assign colon_o     = colon_out_q;
    assign frame_src_o = src_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_frame_scheduler.sv
// ============================================================================
// Module  : tb_seg_frame_scheduler
// Purpose : Self-checking bench: vector table, hand sequences and random
//           bursts scored against a frame-level transfer model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg_frame_scheduler;

    logic        clk;
    logic        reset;
    logic        tick_i;
    logic        a_valid_i;
    logic [15:0] a_frame_i;
    logic        a_colon_i;
    logic        b_valid_i;
    logic [15:0] b_frame_i;
    logic        b_colon_i;
    logic        b_ack_o;
    logic [1:0]  bright_i;
    logic        sh_ready_i;
    logic        sh_start_o;
    logic [3:0]  disp_o;
    logic [1:0]  digit_o;
    logic        colon_o;
    logic        frame_src_o;

    seg_frame_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .tick_i      (tick_i),
        .a_valid_i   (a_valid_i),
        .a_frame_i   (a_frame_i),
        .a_colon_i   (a_colon_i),
        .b_valid_i   (b_valid_i),
        .b_frame_i   (b_frame_i),
        .b_colon_i   (b_colon_i),
        .b_ack_o     (b_ack_o),
        .bright_i    (bright_i),
        .sh_ready_i  (sh_ready_i),
        .sh_start_o  (sh_start_o),
        .disp_o      (disp_o),
        .digit_o     (digit_o),
        .colon_o     (colon_o),
        .frame_src_o (frame_src_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0] disp;
        logic [1:0] dig;
        logic       col;
        logic       src;
    } xfer_t;

    typedef struct {
        logic        a_v;
        logic [15:0] a_f;
        logic        a_c;
        logic        b_v;
        logic [15:0] b_f;
        logic        b_c;
        logic [1:0]  bright;
        logic [15:0] x_disp;
        logic        x_col;
        logic        x_src;
        int          x_ack;
    } vec_t;

    xfer_t exp_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    acc_total = 0;
    int    ack_total = 0;
    int    m_cnt = 0;
    int    busy = 0;
    bit    force_low = 0;
    bit    rmode = 0;
    bit    last_start = 0;

    // Scoreboard: every accepted word must match the next expected transfer,
    // and a stalled start must hold its word unchanged.
    initial begin
        xfer_t e, got;
        bit    stall_prev;
        logic [6:0] prev_word;
        stall_prev = 0;
        prev_word  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    n_cmp++;
                    if (!(sh_start_o && {disp_o, digit_o, colon_o} == prev_word)) begin
                        n_fail++;
                        $display("FAIL hold: start=%0b word=%h required start=1 word=%h",
                                 sh_start_o, {disp_o, digit_o, colon_o}, prev_word);
                    end
                end
                if (sh_start_o && sh_ready_i) begin
                    acc_total++;
                    n_cmp++;
                    got = '{disp_o, digit_o, colon_o, frame_src_o};
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL xfer_unexpected: got disp=%h dig=%0d col=%0b src=%0b",
                                 got.disp, got.dig, got.col, got.src);
                    end else begin
                        e = exp_q.pop_front();
                        if (got != e) begin
                            n_fail++;
                            $display("FAIL xfer: got disp=%h dig=%0d col=%0b src=%0b required disp=%h dig=%0d col=%0b src=%0b",
                                     got.disp, got.dig, got.col, got.src, e.disp, e.dig, e.col, e.src);
                        end
                    end
                end
                if (b_ack_o) ack_total++;
                stall_prev = sh_start_o && !sh_ready_i;
                prev_word  = {disp_o, digit_o, colon_o};
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic push_exp(input logic [15:0] f, input logic col, input logic src);
        logic [15:0] t;
        xfer_t x;
        for (int d = 0; d < 4; d++) begin
            t     = f >> (4 * (3 - d));
            x.disp = t[3:0];
            x.dig  = 2'(d);
            x.col  = col;
            x.src  = src;
            exp_q.push_back(x);
        end
    endtask

    // Frame-level model: pick the winning source, then blank if the frame
    // counter exceeds the brightness level.
    task automatic push_model(input logic av, input logic [15:0] af, input logic ac,
                              input logic bv, input logic [15:0] bf, input logic bc,
                              input logic [1:0] br);
        logic [15:0] f;
        logic        c;
        logic        s;
        s = bv;
        f = bv ? bf : (av ? af : 16'hAAAA);
        c = bv ? bc : (av ? ac : 1'b0);
        if (m_cnt > int'(br)) begin
            f = 16'hAAAA;
            c = 1'b0;
        end
        push_exp(f, c, s);
        m_cnt = (m_cnt + 1) % 4;
    endtask

    // One clock cycle: inputs applied just after the edge, DUT sampled at
    // the falling edge, shifter busy time updated after the next edge.
    task automatic step(input bit tk);
        bit acc;
        tick_i     = tk;
        sh_ready_i = (busy == 0) && !force_low && !(rmode && $urandom_range(3) == 0);
        @(negedge clk);
        acc        = sh_start_o && sh_ready_i;
        last_start = sh_start_o;
        @(posedge clk);
        #1;
        if (acc) busy = rmode ? int'($urandom_range(4, 1)) : 1;
        else if (busy > 0) busy--;
        tick_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic run_until(input int target, input int pct, input int budget);
        int cyc;
        cyc = 0;
        while (acc_total < target && cyc < budget) begin
            step($urandom_range(99) < pct);
            cyc++;
        end
        n_cmp++;
        if (acc_total < target) begin
            n_fail++;
            $display("FAIL timeout: transfers %0d required %0d", acc_total, target);
        end
    endtask

    vec_t tbl[8];

    initial begin
        int a0, base, n;
        logic av, bv, ac, bc;
        logic [15:0] af, bf;
        logic [1:0] br;

        reset = 1; tick_i = 0; a_valid_i = 0; a_frame_i = '0; a_colon_i = 0;
        b_valid_i = 0; b_frame_i = '0; b_colon_i = 0; bright_i = 2'd3; sh_ready_i = 1;

        tbl[0] = '{1'b1, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd3, 16'h1234, 1'b1, 1'b0, 0};
        tbl[1] = '{1'b1, 16'h1234, 1'b1, 1'b1, 16'h5678, 1'b0, 2'd3, 16'h5678, 1'b0, 1'b1, 1};
        tbl[2] = '{1'b0, 16'h1111, 1'b1, 1'b0, 16'h2222, 1'b1, 2'd3, 16'hAAAA, 1'b0, 1'b0, 0};
        tbl[3] = '{1'b1, 16'h9876, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd2, 16'hAAAA, 1'b0, 1'b0, 0};
        tbl[4] = '{1'b1, 16'h9999, 1'b0, 1'b1, 16'h4321, 1'b1, 2'd0, 16'h4321, 1'b1, 1'b1, 1};
        tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 2'd0, 16'hAAAA, 1'b0, 1'b1, 1};
        tbl[6] = '{1'b1, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd1, 16'hAAAA, 1'b0, 1'b0, 0};
        tbl[7] = '{1'b1, 16'h0F0F, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd3, 16'h0F0F, 1'b0, 1'b0, 0};

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_outputs", int'({sh_start_o, b_ack_o, disp_o, digit_o, colon_o, frame_src_o}), 0);
        @(posedge clk);
        #1;
        reset = 0;
        idle(3);

        // Vector table: one frame per record, frame counter starts at 0.
        for (int i = 0; i < 8; i++) begin
            a_valid_i = tbl[i].a_v; a_frame_i = tbl[i].a_f; a_colon_i = tbl[i].a_c;
            b_valid_i = tbl[i].b_v; b_frame_i = tbl[i].b_f; b_colon_i = tbl[i].b_c;
            bright_i  = tbl[i].bright;
            push_exp(tbl[i].x_disp, tbl[i].x_col, tbl[i].x_src);
            m_cnt = (m_cnt + 1) % 4;
            a0 = ack_total;
            run_until(acc_total + 4, 40, 400);
            idle(10);
            check($sformatf("tbl%0d_ack", i), ack_total - a0, tbl[i].x_ack);
            b_valid_i = 0;
        end

        // Start latency from IDLE, long shifter stall, latency from HOLD.
        a_valid_i = 1; a_frame_i = 16'h3579; a_colon_i = 1; bright_i = 2'd3;
        push_model(1, 16'h3579, 1, 0, 16'h0000, 0, 2'd3);
        base = acc_total;
        force_low = 1;
        step(1);
        step(0);
        check("lat_idle_c1", int'(last_start), 0);
        step(0);
        check("lat_idle_c2", int'(last_start), 1);
        idle(18);
        check("stall_no_xfer", acc_total - base, 0);
        force_low = 0;
        idle(4);
        check("stall_one_xfer", acc_total - base, 1);
        step(1);
        check("lat_hold_c0", int'(last_start), 0);
        step(0);
        check("lat_hold_c1", int'(last_start), 1);
        run_until(base + 4, 50, 400);
        idle(10);

        // Source changes mid-frame: current frame keeps old A, next is B.
        a_frame_i = 16'h2468; a_colon_i = 0;
        push_model(1, 16'h2468, 0, 0, 16'h0000, 0, 2'd3);
        push_model(1, 16'hFFFF, 0, 1, 16'h1357, 1, 2'd3);
        base = acc_total;
        a0 = ack_total;
        run_until(base + 1, 50, 400);
        a_frame_i = 16'hFFFF; b_valid_i = 1; b_frame_i = 16'h1357; b_colon_i = 1;
        run_until(base + 8, 50, 800);
        idle(10);
        check("midframe_b_ack", ack_total - a0, 1);
        b_valid_i = 0;

        // Randomised bursts with constant sources per burst.
        for (int k = 0; k < 25; k++) begin
            av = 1'($urandom_range(1)); bv = ($urandom_range(3) == 0);
            af = 16'($urandom()); bf = 16'($urandom());
            ac = 1'($urandom_range(1)); bc = 1'($urandom_range(1));
            br = 2'($urandom_range(3)); n = int'($urandom_range(3, 1));
            a_valid_i = av; a_frame_i = af; a_colon_i = ac;
            b_valid_i = bv; b_frame_i = bf; b_colon_i = bc; bright_i = br;
            for (int j = 0; j < n; j++) push_model(av, af, ac, bv, bf, bc, br);
            a0 = ack_total;
            rmode = 1;
            run_until(acc_total + 4 * n, int'($urandom_range(70, 10)), 400 * n);
            rmode = 0;
            idle(12);
            check($sformatf("rand%0d_ack", k), ack_total - a0, bv ? n : 0);
            b_valid_i = 0;
        end

        // Reset in WAIT of digit 2 of a B frame, then restart with bright 0.
        a_valid_i = 0; b_valid_i = 1; b_frame_i = 16'h9ABC; b_colon_i = 1; bright_i = 2'd3;
        push_model(0, 16'h0000, 0, 1, 16'h9ABC, 1, 2'd3);
        a0 = ack_total;
        run_until(acc_total + 3, 50, 400);
        force_low = 1;
        step(0);
        step(0);
        reset = 1;
        step(0);
        reset = 0;
        @(negedge clk);
        check("reset_mid_outputs", int'({sh_start_o, b_ack_o, disp_o, digit_o, colon_o, frame_src_o}), 0);
        check("reset_mid_no_ack", ack_total - a0, 0);
        @(posedge clk);
        #1;
        force_low = 0; busy = 0; b_valid_i = 0;
        exp_q.delete();
        m_cnt = 0;

        a_valid_i = 1; a_frame_i = 16'h8421; a_colon_i = 1; bright_i = 2'd0;
        for (int j = 0; j < 8; j++) push_model(1, 16'h8421, 1, 0, 16'h0000, 0, 2'd0);
        run_until(acc_total + 32, 50, 4000);
        idle(10);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
